// File: rtl/fault_confine_fsm.sv
// CAN fault-confinement state machine: error-active / error-passive / bus-off
// tracking, bus-off recovery via seq11 edges, and the TEC/REC clear strobe.
module fault_confine_fsm #(
    parameter int RECOVER_CNT = 128,
    parameter int CNT_W       = 8,
    parameter int RST_CYCLES  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tec_lt96,
    input  logic             tec_ge96,
    input  logic             tec_ge128,
    input  logic             tec_ge256,
    input  logic             rec_ge96,
    input  logic             rec_ge128,
    input  logic             seq11,
    output logic             erroractive,
    output logic             errorpassive,
    output logic             busoff,
    output logic             warning,
    output logic             cnt_rst_n,
    output logic [CNT_W-1:0] recovercount,
    output logic             fault_irq
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {ERRACT, ERRPAS, BUSOFF, RSTCNT} state_t;

    state_t           r_state, w_next;
    logic             r_seq11_q;
    logic [CNT_W-1:0] r_count, w_count;
    logic [RC_W-1:0]  r_rcnt, w_rcnt;
    logic             r_warning, r_irq, r_cnt_rst_n;
    logic             w_edge, w_bus_next, w_irq, w_warning;
    logic             w_unused;

    // tec_lt96 carries no information beyond tec_ge96 for confinement decisions.
    assign w_unused = tec_lt96;
    assign w_edge   = seq11 & ~r_seq11_q;

    // Confinement group: error-active, error-passive, or bus-off (BUSOFF and RSTCNT).
    function automatic logic [1:0] group_of(input state_t s);
        case (s)
            ERRACT:  group_of = 2'd0;
            ERRPAS:  group_of = 2'd1;
            default: group_of = 2'd2;
        endcase
    endfunction

    always_comb begin
        w_next  = r_state;
        w_count = r_count;
        w_rcnt  = r_rcnt;
        case (r_state)
            ERRACT: begin
                w_count = '0;
                if (tec_ge256)                   w_next = BUSOFF;
                else if (tec_ge128 || rec_ge128) w_next = ERRPAS;
            end
            ERRPAS: begin
                w_count = '0;
                if (tec_ge256)                      w_next = BUSOFF;
                else if (!tec_ge128 && !rec_ge128)  w_next = ERRACT;
            end
            BUSOFF: begin
                w_rcnt = '0;
                if (w_edge && (r_count != CNT_W'(RECOVER_CNT))) begin
                    w_count = r_count + 1'b1;
                    if (w_count == CNT_W'(RECOVER_CNT)) w_next = RSTCNT;
                end
            end
            RSTCNT: begin
                if (r_rcnt == RC_W'(RST_CYCLES - 1)) begin
                    w_next  = ERRACT;
                    w_count = '0;
                    w_rcnt  = '0;
                end else begin
                    w_rcnt = r_rcnt + 1'b1;
                end
            end
            default: w_next = ERRACT;
        endcase
    end

    assign w_bus_next = (w_next == BUSOFF) || (w_next == RSTCNT);
    assign w_irq      = group_of(w_next) != group_of(r_state);
    // Warning is masked against the state being entered so it drops with busoff.
    assign w_warning  = (tec_ge96 | rec_ge96) & ~w_bus_next;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ERRACT;
            r_seq11_q   <= 1'b0;
            r_count     <= '0;
            r_rcnt      <= '0;
            r_warning   <= 1'b0;
            r_irq       <= 1'b0;
            r_cnt_rst_n <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_seq11_q   <= seq11;
            r_count     <= w_count;
            r_rcnt      <= w_rcnt;
            r_warning   <= w_warning;
            r_irq       <= w_irq;
            r_cnt_rst_n <= (w_next != RSTCNT);
        end
    end

    assign erroractive  = (r_state == ERRACT);
    assign errorpassive = (r_state == ERRPAS);
    assign busoff       = (r_state == BUSOFF) || (r_state == RSTCNT);
    assign warning      = r_warning;
    assign cnt_rst_n    = r_cnt_rst_n;
    assign recovercount = r_count;
    assign fault_irq    = r_irq;

endmodule

// File: tb/tb_fault_confine_fsm.sv
// Scoreboard bench for fault_confine_fsm: directed stimulus pushes the expected
// output vector per cycle; a negedge monitor pops and compares.
module tb_fault_confine_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tec_lt96 = 1'b1, tec_ge96 = 1'b0, tec_ge128 = 1'b0, tec_ge256 = 1'b0;
    logic       rec_ge96 = 1'b0, rec_ge128 = 1'b0, seq11 = 1'b0;
    logic       erroractive, errorpassive, busoff, warning, cnt_rst_n, fault_irq;
    logic [7:0] recovercount;

    fault_confine_fsm #(.RECOVER_CNT(128), .CNT_W(8), .RST_CYCLES(2)) dut (
        .clock(clock), .reset(reset),
        .tec_lt96(tec_lt96), .tec_ge96(tec_ge96), .tec_ge128(tec_ge128), .tec_ge256(tec_ge256),
        .rec_ge96(rec_ge96), .rec_ge128(rec_ge128), .seq11(seq11),
        .erroractive(erroractive), .errorpassive(errorpassive), .busoff(busoff),
        .warning(warning), .cnt_rst_n(cnt_rst_n), .recovercount(recovercount),
        .fault_irq(fault_irq)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       ea, ep, bo, warn, crn;
        logic [7:0] rc;
        logic       irq;
    } exp_t;

    typedef struct {
        int    due;
        exp_t  e;
        string nm;
    } sb_t;

    sb_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    // Input vector bits: {reset, tec_ge96, tec_ge128, tec_ge256, rec_ge96, rec_ge128, seq11}
    localparam logic [6:0] RST  = 7'b0000000;
    localparam logic [6:0] IDLE = 7'b1000000;
    localparam logic [6:0] SEQ  = 7'b1000001;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t E(input logic ea, ep, bo, w, crn, input logic [7:0] rc, input logic irq);
        return '{ea: ea, ep: ep, bo: bo, warn: w, crn: crn, rc: rc, irq: irq};
    endfunction

    task automatic go(input logic [6:0] in, input exp_t e, input string nm);
        @(posedge clock);
        #1;
        {reset, tec_ge96, tec_ge128, tec_ge256, rec_ge96, rec_ge128, seq11} = in;
        tec_lt96 = ~in[5];
        q.push_back('{due: cyc + 1, e: e, nm: nm});
    endtask

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            sb_t  it;
            exp_t act;
            it  = q.pop_front();
            act = '{ea: erroractive, ep: errorpassive, bo: busoff, warn: warning,
                    crn: cnt_rst_n, rc: recovercount, irq: fault_irq};
            checks++;
            if (act !== it.e) begin
                failures++;
                $display("FAIL %s cyc=%0d got ea=%b ep=%b bo=%b warn=%b crn=%b rc=%0d irq=%b want ea=%b ep=%b bo=%b warn=%b crn=%b rc=%0d irq=%b",
                         it.nm, cyc, act.ea, act.ep, act.bo, act.warn, act.crn, act.rc, act.irq,
                         it.e.ea, it.e.ep, it.e.bo, it.e.warn, it.e.crn, it.e.rc, it.e.irq);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        go(RST, E(1,0,0,0,1,0,0), "t1_rst0");
        go(RST, E(1,0,0,0,1,0,0), "t1_rst1");
        go(IDLE, E(1,0,0,0,1,0,0), "t1_idle");

        // Warning and active/passive transitions
        go(7'b1100000, E(1,0,0,1,1,0,0), "t2_warn");
        go(7'b1100110, E(0,1,0,1,1,0,1), "t2_passive");
        go(7'b1100110, E(0,1,0,1,1,0,0), "t2_passive_hold");
        go(7'b1100000, E(1,0,0,1,1,0,1), "t2_active");
        go(7'b1100000, E(1,0,0,1,1,0,0), "t2_active_hold");

        // ge128 and ge256 together: straight to bus-off
        go(7'b1111000, E(0,0,1,0,1,0,1), "t3_busoff");
        go(7'b1111000, E(0,0,1,0,1,0,0), "t3_busoff_hold");

        // Full recovery: 128 pulses, each held 3 cycles
        for (int p = 1; p <= 127; p++) begin
            for (int k = 0; k < 3; k++) go(SEQ, E(0,0,1,0,1,8'(p),0), "t4_pulse_hi");
            go(IDLE, E(0,0,1,0,1,8'(p),0), "t4_pulse_lo");
        end
        go(SEQ, E(0,0,1,0,0,8'd128,0), "t4_rstcnt0");
        go(SEQ, E(0,0,1,0,0,8'd128,0), "t4_rstcnt1");
        go(SEQ, E(1,0,0,0,1,8'd0,1),   "t4_recovered");
        go(IDLE, E(1,0,0,0,1,8'd0,0),  "t4_after");

        // Inconsistent flags enter bus-off; long seq11 counts once
        go(7'b1001000, E(0,0,1,0,1,0,1), "t5_busoff_ge256_only");
        go(IDLE, E(0,0,1,0,1,0,0), "t5_busoff_hold");
        for (int k = 0; k < 50; k++) go(SEQ, E(0,0,1,0,1,8'd1,0), "t5_seq_held");
        go(IDLE, E(0,0,1,0,1,8'd1,0), "t5_seq_release");
        go(IDLE, E(0,0,1,0,1,8'd1,0), "t5_seq_release2");

        // Reset at recovercount=60
        for (int p = 2; p <= 60; p++) begin
            go(SEQ,  E(0,0,1,0,1,8'(p),0), "t6a_pulse_hi");
            go(IDLE, E(0,0,1,0,1,8'(p),0), "t6a_pulse_lo");
        end
        go(RST,  E(1,0,0,0,1,0,0), "t6a_rst_at60");
        go(IDLE, E(1,0,0,0,1,0,0), "t6a_after");

        // Reset during RSTCNT
        go(7'b1001000, E(0,0,1,0,1,0,1), "t6b_busoff");
        for (int p = 1; p <= 127; p++) begin
            go(SEQ,  E(0,0,1,0,1,8'(p),0), "t6b_pulse_hi");
            go(IDLE, E(0,0,1,0,1,8'(p),0), "t6b_pulse_lo");
        end
        go(SEQ,  E(0,0,1,0,0,8'd128,0), "t6b_rstcnt");
        go(RST,  E(1,0,0,0,1,0,0), "t6b_rst_in_rstcnt");
        go(IDLE, E(1,0,0,0,1,0,0), "t6b_after0");
        go(IDLE, E(1,0,0,0,1,0,0), "t6b_after1");

        // Passive to bus-off
        go(7'b1110000, E(0,1,0,1,1,0,1), "t7_passive");
        go(7'b1111000, E(0,0,1,0,1,0,1), "t7_pas_to_busoff");
        go(RST,        E(1,0,0,0,1,0,0), "t7_rst");

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
